centroid_finder: RTL and testbench
==================================

CENTROID_FINDER -- requirements
Module: centroid_finder

Interface
REQ-001 SHALL have parameter R_MIN, default 5'd28, minimum red channel (pixel[15:11]) for a lit pixel.
REQ-002 SHALL have parameter G_MAX, default 6'd40, maximum green channel (pixel[10:5]) for a lit pixel.
REQ-003 SHALL have parameter MIN_PIXELS, default 4, minimum lit-pixel count for a valid detection; must be >= 1.
REQ-004 SHALL have port system_clk_in, input, 1, the single clock (65 MHz); all logic on its rising edge.
REQ-005 SHALL have port rst_n_in, input, 1, synchronous active-low reset.
REQ-006 SHALL have port data_valid_in, input, 1, one-cycle pixel strobe from the recovered-pixel stage.
REQ-007 SHALL have port pixel_in, input, 16, RGB565 pixel qualified by data_valid_in.
REQ-008 SHALL have port hcount_in, input, 11, pixel column, 0..319.
REQ-009 SHALL have port vcount_in, input, 10, pixel row, 0..239.
REQ-010 SHALL have port frame_done_in, input, 1, end-of-frame pulse.
REQ-011 SHALL have port centroid_x_out, output, 11, floor of the mean column of lit pixels.
REQ-012 SHALL have port centroid_y_out, output, 10, floor of the mean row of lit pixels.
REQ-013 SHALL have port found_out, output, 1, lit count >= MIN_PIXELS for the reported frame.
REQ-014 SHALL have port centroid_valid_out, output, 1, one-cycle pulse marking new centroid/found values.
REQ-015 SHALL have port overrun_out, output, 1, one-cycle pulse when a frame is dropped.

Function
REQ-016 SHALL classify a pixel as lit when data_valid_in=1, pixel[15:11] >= R_MIN, pixel[10:5] <= G_MAX, hcount_in < 320 and vcount_in < 240; otherwise ignore it.
REQ-017 SHALL accumulate per frame: count (17 b), sum_x (25 b), sum_y (25 b); widths sized so 320x240 all-lit cannot overflow.
REQ-018 SHALL, on a cycle with frame_done_in=1, include any lit pixel in that same cycle, snapshot the three accumulators and clear them to 0 on the next edge.
REQ-019 SHALL keep accumulating the next frame while the snapshot is being processed.
REQ-020 SHALL use FSM states IDLE, DIV_X, DIV_Y, REPORT: IDLE->DIV_X on frame_done_in; DIV_X->DIV_Y on divider done; DIV_Y->REPORT on divider done; REPORT->IDLE after one cycle.
REQ-021 SHALL compute sum_x/count then sum_y/count sequentially on one shared 25-bit restoring divider, 25 cycles per division, quotient truncated toward zero.
REQ-022 SHALL assert centroid_valid_out exactly 52 cycles after the edge sampling frame_done_in, in REPORT.
REQ-023 SHALL, when snapshot count < MIN_PIXELS, still run the fixed 52-cycle sequence (divider inputs forced to 0/1) and report found_out=0, centroid_x_out=0, centroid_y_out=0; division by zero never occurs.
REQ-024 SHALL hold centroid_x_out, centroid_y_out, found_out stable between centroid_valid_out pulses.
REQ-025 SHALL, on frame_done_in when state != IDLE, pulse overrun_out the next cycle, discard that frame's accumulators (cleared as in REQ-018), and not disturb the division in progress.

Reset
REQ-026 SHALL, while rst_n_in=0 at a rising edge, set state IDLE, all accumulators and snapshots 0, all outputs 0.
REQ-027 SHALL abort any in-progress division on reset; no centroid_valid_out pulse for the aborted frame.
REQ-028 SHALL ignore data_valid_in and frame_done_in in any cycle where rst_n_in=0.

Structure
REQ-029 SHALL take H_ACTIVE=320, V_ACTIVE=240, CNT_W=17, ACC_W=25 and the FSM state enum from shared package lightboard_pkg.
REQ-030 SHALL implement the divider as sub-module seq_divider (start/done handshake, dividend ACC_W bits, divisor CNT_W bits, done one-cycle pulse 25 cycles after start).

Verification
REQ-031 SHALL cover: 2x2 lit block at cols 100-101, rows 50-51, then frame_done -> at +52 cycles valid pulse, x=100, y=50, found=1.
REQ-032 SHALL cover: frame with no lit pixels -> valid at +52, found=0, x=0, y=0.
REQ-033 SHALL cover: all 76800 pixels lit -> x=159, y=119, found=1, no accumulator overflow.
REQ-034 SHALL cover: thresholds -> R=R_MIN,G=G_MAX counted; R=R_MIN-1 or G=G_MAX+1 not counted (3 accepted pixels with MIN_PIXELS=4 gives found=0).
REQ-035 SHALL cover: second frame_done 10 cycles after first -> overrun_out pulse, first result unchanged at +52, following frame reports normally.
REQ-036 SHALL cover: rst_n_in low at cycle 20 of DIV_X -> no valid pulse, all outputs 0, next frame reports correctly.

Source files
------------

// File: rtl/lightboard_pkg.sv
// Shared sizing, FSM encoding and the restoring-division step used by the
// centroid finder and its sequential divider.
package lightboard_pkg;

    localparam int H_ACTIVE   = 320;
    localparam int V_ACTIVE   = 240;
    localparam int CNT_W      = 17;
    localparam int ACC_W      = 25;
    localparam int DIV_CYCLES = 25;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIV_X  = 2'd1,
        DIV_Y  = 2'd2,
        REPORT = 2'd3
    } cf_state_e;

    // One restoring step: shift the next dividend bit into the remainder and
    // subtract the divisor when it fits. Returns {remainder, quotient_shift}.
    function automatic logic [CNT_W+ACC_W-1:0] div_step(
        input logic [CNT_W-1:0] rem,
        input logic [ACC_W-1:0] quo,
        input logic [CNT_W-1:0] dvs
    );
        logic [CNT_W:0] trial;
        trial = {rem, quo[ACC_W-1]};
        if (trial >= {1'b0, dvs}) begin
            return {trial[CNT_W-1:0] - dvs, quo[ACC_W-2:0], 1'b1};
        end
        return {trial[CNT_W-1:0], quo[ACC_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle; done pulses on the cycle
// after the last of DIV_CYCLES steps, the first step happening on start.
module seq_divider
    import lightboard_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [ACC_W-1:0] dividend_i,
    input  logic [CNT_W-1:0] divisor_i,
    output logic [ACC_W-1:0] quotient_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int SW = $clog2(DIV_CYCLES + 1);

    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] dvs_q, dvs_d;
    logic [ACC_W-1:0] quo_q, quo_d;
    logic [SW-1:0]    steps_q, steps_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        steps_d = steps_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (start_i) begin
            {rem_d, quo_d} = div_step('0, dividend_i, divisor_i);
            dvs_d   = divisor_i;
            steps_d = SW'(DIV_CYCLES - 1);
            busy_d  = 1'b1;
        end else if (busy_q) begin
            {rem_d, quo_d} = div_step(rem_q, quo_q, dvs_q);
            steps_d = steps_q - SW'(1);
            if (steps_q == SW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            steps_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            steps_q <= steps_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign quotient_o = quo_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: rtl/centroid_finder.sv
// Accumulates lit-pixel statistics per frame and reports the floored mean
// column/row through a shared sequential divider, 52 cycles after frame end.
//
// state  | meaning
// IDLE   | waiting for frame_done_in with a fresh snapshot
// DIV_X  | dividing snapshot sum_x by count
// DIV_Y  | dividing snapshot sum_y by count
// REPORT | publishing centroid/found, one cycle
module centroid_finder
    import lightboard_pkg::*;
#(
    parameter logic [4:0] R_MIN      = 5'd28,
    parameter logic [5:0] G_MAX      = 6'd40,
    parameter int         MIN_PIXELS = 4
) (
    input  logic        system_clk_in,
    input  logic        rst_n_in,
    input  logic        data_valid_in,
    input  logic [15:0] pixel_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        frame_done_in,
    output logic [10:0] centroid_x_out,
    output logic [9:0]  centroid_y_out,
    output logic        found_out,
    output logic        centroid_valid_out,
    output logic        overrun_out
);

    localparam logic [CNT_W-1:0] MIN_PIX_C = CNT_W'(MIN_PIXELS);

    cf_state_e state_q, state_d;

    logic             lit;
    logic [CNT_W-1:0] cnt_acc_q, cnt_acc_d, cnt_inc, cnt_snap_q;
    logic [ACC_W-1:0] sx_acc_q, sx_acc_d, sx_inc, sx_snap_q;
    logic [ACC_W-1:0] sy_acc_q, sy_acc_d, sy_inc, sy_snap_q;
    logic             found_snap;

    logic [10:0]      x_tmp_q, cx_q;
    logic [9:0]       cy_q;
    logic             found_q;
    logic             overrun_q;

    logic             div_start, div_busy, div_done;
    logic [ACC_W-1:0] div_dividend, div_quo;
    logic [CNT_W-1:0] div_divisor;
    logic             valid_c;

    assign lit = data_valid_in
              && (pixel_in[15:11] >= R_MIN)
              && (pixel_in[10:5] <= G_MAX)
              && (hcount_in < 11'(H_ACTIVE))
              && (vcount_in < 10'(V_ACTIVE));

    // The incremented values include a lit pixel arriving with frame_done_in.
    always_comb begin
        cnt_inc = cnt_acc_q + CNT_W'(lit);
        sx_inc  = sx_acc_q + (lit ? ACC_W'(hcount_in) : '0);
        sy_inc  = sy_acc_q + (lit ? ACC_W'(vcount_in) : '0);
        if (frame_done_in) begin
            cnt_acc_d = '0;
            sx_acc_d  = '0;
            sy_acc_d  = '0;
        end else begin
            cnt_acc_d = cnt_inc;
            sx_acc_d  = sx_inc;
            sy_acc_d  = sy_inc;
        end
    end

    assign found_snap = (cnt_snap_q >= MIN_PIX_C);

    always_ff @(posedge system_clk_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_done_in) state_d = DIV_X;
            DIV_X:   if (div_done)      state_d = DIV_Y;
            DIV_Y:   if (div_done)      state_d = REPORT;
            REPORT:                     state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // Too few pixels: divide 0 by 1 so the timing stays fixed and the result is 0.
    always_comb begin
        div_start    = 1'b0;
        div_dividend = '0;
        div_divisor  = CNT_W'(1);
        valid_c      = 1'b0;
        case (state_q)
            DIV_X: begin
                div_start = !div_busy && !div_done;
                if (found_snap) begin
                    div_dividend = sx_snap_q;
                    div_divisor  = cnt_snap_q;
                end
            end
            DIV_Y: begin
                div_start = !div_busy && !div_done;
                if (found_snap) begin
                    div_dividend = sy_snap_q;
                    div_divisor  = cnt_snap_q;
                end
            end
            REPORT:  valid_c = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge system_clk_in) begin
        if (!rst_n_in) begin
            cnt_acc_q  <= '0;
            sx_acc_q   <= '0;
            sy_acc_q   <= '0;
            cnt_snap_q <= '0;
            sx_snap_q  <= '0;
            sy_snap_q  <= '0;
            x_tmp_q    <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            found_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            cnt_acc_q <= cnt_acc_d;
            sx_acc_q  <= sx_acc_d;
            sy_acc_q  <= sy_acc_d;
            overrun_q <= frame_done_in && (state_q != IDLE);
            if (frame_done_in && (state_q == IDLE)) begin
                cnt_snap_q <= cnt_inc;
                sx_snap_q  <= sx_inc;
                sy_snap_q  <= sy_inc;
            end
            if ((state_q == DIV_X) && div_done) begin
                x_tmp_q <= div_quo[10:0];
            end
            if ((state_q == DIV_Y) && div_done) begin
                cx_q    <= x_tmp_q;
                cy_q    <= div_quo[9:0];
                found_q <= found_snap;
            end
        end
    end

    seq_divider u_div (
        .clk_i      (system_clk_in),
        .rst_n_i    (rst_n_in),
        .start_i    (div_start),
        .dividend_i (div_dividend),
        .divisor_i  (div_divisor),
        .quotient_o (div_quo),
        .busy_o     (div_busy),
        .done_o     (div_done)
    );

    // Blue channel and upper quotient bits (mean is always < 320) are not needed.
    logic unused_bits;
    assign unused_bits = ^{pixel_in[4:0], div_quo[ACC_W-1:11]};

    assign centroid_x_out     = cx_q;
    assign centroid_y_out     = cy_q;
    assign found_out          = found_q;
    assign centroid_valid_out = valid_c;
    assign overrun_out        = overrun_q;

endmodule

// File: tb/tb_centroid_finder.sv
// Scoreboard bench for centroid_finder: a frame-level reference model queues
// expected reports and overrun pulses; a monitor checks every cycle.
module tb_centroid_finder;

    localparam logic [4:0] R_MIN      = 5'd28;
    localparam logic [5:0] G_MAX      = 6'd40;
    localparam int         MIN_PIXELS = 4;
    localparam int         LATENCY    = 52;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dv;
    logic [15:0] pix;
    logic [10:0] hc;
    logic [9:0]  vc;
    logic        fd;
    logic [10:0] cx;
    logic [9:0]  cy;
    logic        found;
    logic        cvalid;
    logic        overrun;

    always #5 clk = ~clk;

    centroid_finder #(
        .R_MIN      (R_MIN),
        .G_MAX      (G_MAX),
        .MIN_PIXELS (MIN_PIXELS)
    ) dut (
        .system_clk_in      (clk),
        .rst_n_in           (rst_n),
        .data_valid_in      (dv),
        .pixel_in           (pix),
        .hcount_in          (hc),
        .vcount_in          (vc),
        .frame_done_in      (fd),
        .centroid_x_out     (cx),
        .centroid_y_out     (cy),
        .found_out          (found),
        .centroid_valid_out (cvalid),
        .overrun_out        (overrun)
    );

    typedef struct {
        int x;
        int y;
        bit found;
        int due;
    } exp_t;

    exp_t expq[$];
    int   ovq[$];
    exp_t last_rep;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    // Frame-level reference state
    int m_cnt = 0;
    int m_sx  = 0;
    int m_sy  = 0;
    int m_last_acc = -1000;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] mkpix(input int r, input int g, input int b);
        logic [4:0] r5;
        logic [5:0] g6;
        logic [4:0] b5;
        r5 = 5'(r);
        g6 = 6'(g);
        b5 = 5'(b);
        return {r5, g6, b5};
    endfunction

    task automatic drive(input logic r, input logic d, input logic [15:0] p,
                         input int h, input int v, input logic f);
        int  edge_n;
        bit  is_lit;
        exp_t e;
        @(negedge clk);
        rst_n = r;
        dv    = d;
        pix   = p;
        hc    = 11'(h);
        vc    = 10'(v);
        fd    = f;
        edge_n = cyc + 1;
        if (!r) begin
            m_cnt = 0; m_sx = 0; m_sy = 0;
            m_last_acc = -1000;
            expq.delete();
            ovq.delete();
            last_rep = '{0, 0, 1'b0, 0};
        end else begin
            is_lit = d && (int'(p[15:11]) >= int'(R_MIN)) && (int'(p[10:5]) <= int'(G_MAX))
                     && (h < 320) && (v < 240);
            if (is_lit) begin
                m_cnt += 1; m_sx += h; m_sy += v;
            end
            if (f) begin
                if (edge_n - m_last_acc <= LATENCY + 1) begin
                    ovq.push_back(edge_n);
                end else begin
                    e.found = (m_cnt >= MIN_PIXELS);
                    e.x     = e.found ? m_sx / m_cnt : 0;
                    e.y     = e.found ? m_sy / m_cnt : 0;
                    e.due   = edge_n + LATENCY;
                    expq.push_back(e);
                    m_last_acc = edge_n;
                end
                m_cnt = 0; m_sx = 0; m_sy = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 16'h0, 0, 0, 1'b0);
    endtask

    task automatic rand_pixels(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, ($urandom_range(0, 3) != 0),
                  mkpix($urandom_range(24, 31), $urandom_range(30, 50), $urandom_range(0, 31)),
                  $urandom_range(0, 340), $urandom_range(0, 250), 1'b0);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    always begin : monitor
        exp_t e;
        bit   exp_ov;
        @(posedge clk);
        #1;
        while (expq.size() > 0 && expq[0].due < cyc) begin
            e = expq.pop_front();
            n_checks++;
            n_errors++;
            $display("FAIL valid_missing: no centroid_valid_out at cycle %0d, expected x=%0d y=%0d found=%0d",
                     e.due, e.x, e.y, e.found);
        end
        if (cvalid === 1'b1) begin
            n_checks++;
            if (expq.size() == 0) begin
                n_errors++;
                $display("FAIL valid_unexpected: centroid_valid_out=1 at cycle %0d, expected 0", cyc);
            end else begin
                e = expq.pop_front();
                if (e.due != cyc || int'(cx) != e.x || int'(cy) != e.y || found !== e.found) begin
                    n_errors++;
                    $display("FAIL report: got cycle=%0d x=%0d y=%0d found=%0b, expected cycle=%0d x=%0d y=%0d found=%0b",
                             cyc, cx, cy, found, e.due, e.x, e.y, e.found);
                end
                last_rep = e;
            end
        end else begin
            n_checks++;
            if (cvalid !== 1'b0 || int'(cx) != last_rep.x || int'(cy) != last_rep.y
                || found !== last_rep.found) begin
                n_errors++;
                $display("FAIL hold: cycle %0d got valid=%0b x=%0d y=%0d found=%0b, expected valid=0 x=%0d y=%0d found=%0b",
                         cyc, cvalid, cx, cy, found, last_rep.x, last_rep.y, last_rep.found);
            end
        end
        exp_ov = 1'b0;
        if (ovq.size() > 0 && ovq[0] == cyc) begin
            exp_ov = 1'b1;
            void'(ovq.pop_front());
        end
        n_checks++;
        if (overrun !== exp_ov) begin
            n_errors++;
            $display("FAIL overrun: cycle %0d got %0b, expected %0b", cyc, overrun, exp_ov);
        end
    end

    initial begin
        rst_n = 1'b0; dv = 1'b0; pix = '0; hc = '0; vc = '0; fd = 1'b0;
        last_rep = '{0, 0, 1'b0, 0};
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 16'h0, 0, 0, 1'b0);
        idle(3);

        // 2x2 block at cols 100-101, rows 50-51 plus unlit distractors
        drive(1'b1, 1'b1, mkpix(31, 0, 0), 100, 50, 1'b0);
        drive(1'b1, 1'b1, mkpix(10, 0, 0), 200, 200, 1'b0);
        drive(1'b1, 1'b1, mkpix(31, 0, 0), 101, 50, 1'b0);
        drive(1'b1, 1'b1, mkpix(31, 0, 0), 100, 51, 1'b0);
        drive(1'b1, 1'b0, mkpix(31, 0, 0), 300, 10, 1'b0);
        drive(1'b1, 1'b1, mkpix(31, 0, 0), 101, 51, 1'b0);
        drive(1'b1, 1'b0, 16'h0, 0, 0, 1'b1);
        idle(60);

        // Frame with no lit pixels
        drive(1'b1, 1'b0, 16'h0, 0, 0, 1'b1);
        idle(60);

        // Threshold edges: three accepted, rest rejected -> found=0
        drive(1'b1, 1'b1, mkpix(R_MIN, G_MAX, 0), 10, 10, 1'b0);
        drive(1'b1, 1'b1, mkpix(R_MIN, G_MAX, 31), 20, 20, 1'b0);
        drive(1'b1, 1'b1, mkpix(31, 0, 0), 30, 30, 1'b0);
        drive(1'b1, 1'b1, mkpix(R_MIN - 1, 0, 0), 40, 40, 1'b0);
        drive(1'b1, 1'b1, mkpix(31, G_MAX + 1, 0), 50, 50, 1'b0);
        drive(1'b1, 1'b1, mkpix(31, 0, 0), 320, 5, 1'b0);
        drive(1'b1, 1'b1, mkpix(31, 0, 0), 5, 240, 1'b0);
        drive(1'b1, 1'b0, 16'h0, 0, 0, 1'b1);
        idle(60);

        // Random frames, back to back while the previous one divides
        for (int f = 0; f < 8; f++) begin
            rand_pixels(70);
            drive(1'b1, 1'b1, mkpix(31, 0, 0), $urandom_range(0, 319), $urandom_range(0, 239), 1'b1);
        end
        idle(60);

        // Overrun: second frame_done 10 cycles after the first
        rand_pixels(40);
        drive(1'b1, 1'b0, 16'h0, 0, 0, 1'b1);
        rand_pixels(9);
        drive(1'b1, 1'b1, mkpix(31, 0, 0), 7, 7, 1'b1);
        rand_pixels(60);
        drive(1'b1, 1'b0, 16'h0, 0, 0, 1'b1);
        idle(60);

        // Reset during DIV_X cycle 20; inputs active while in reset are ignored
        rand_pixels(30);
        drive(1'b1, 1'b0, 16'h0, 0, 0, 1'b1);
        idle(19);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, mkpix(31, 0, 0), 60, 60, 1'b1);
        rand_pixels(50);
        drive(1'b1, 1'b0, 16'h0, 0, 0, 1'b1);
        idle(60);

        // Every pixel lit; frame_done on the last pixel
        for (int v = 0; v < 240; v++) begin
            for (int h = 0; h < 320; h++) begin
                drive(1'b1, 1'b1, mkpix(31, 0, 0), h, v, (v == 239 && h == 319));
            end
        end
        idle(60);

        n_checks++;
        if (expq.size() != 0 || ovq.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d reports and %0d overruns outstanding, expected 0 and 0",
                     expq.size(), ovq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
